// File: rtl/instr_boot_loader.sv
// ---------------------------------------------------------------------------
// instr_boot_loader
// Boot sequencer for the single-cycle RV32I core. While the core is held in
// reset, a program image arrives as a UART byte stream:
//   0xA5 | LEN (4 bytes, LSB first) | LEN words (4 bytes each, LSB first) | CSUM
// Each completed word is written into instruction memory. If the XOR of all
// payload bytes matches CSUM, the core is released to run from BASE_ADDR.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_valid    one-cycle strobe, rx_data holds a new byte (always accepted)
//   rx_data     received byte
//   imem_wr_en  one-cycle instruction-memory write strobe
//   imem_wAddr  byte address of the written word (word aligned)
//   imem_wData  word written
//   core_reset  reset to the core, high until a good image is loaded
//   boot_done   high once the core is released
//   boot_err    high after a failed frame, until the next frame start
// ---------------------------------------------------------------------------
module instr_boot_loader #(
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_wr_en,
    output logic [31:0] imem_wAddr,
    output logic [31:0] imem_wData,
    output logic        core_reset,
    output logic        boot_done,
    output logic        boot_err
);

    localparam int IDX_W = $clog2(IMEM_DEPTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [31:0]       shift_reg;
    logic [31:0]       len_words;
    logic [IDX_W-1:0]  word_idx;
    logic [7:0]        csum;
    logic [CNT_W-1:0]  idle_cnt;

    logic [31:0]       next_word;
    logic [31:0]       word_offset;
    logic              last_word;
    logic              in_frame;

    // Bytes arrive LSB first, so each new byte enters at the top and the
    // earlier ones slide down; after four bytes byte 0 sits in bits 7:0.
    assign next_word   = {rx_data, shift_reg[31:8]};
    assign word_offset = 32'(word_idx) << 2;
    assign last_word   = (32'(word_idx) == (len_words - 32'd1));
    assign in_frame    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);

    // Frame parser, memory write port and core release, all registered in
    // one process. The write strobe defaults low so it lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            len_words  <= '0;
            word_idx   <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
            imem_wr_en <= 1'b0;
            imem_wAddr <= BASE_ADDR;
            imem_wData <= '0;
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;

            // A byte in the expiry cycle takes priority over the timeout,
            // so the timeout only fires on a cycle with no byte.
            if (in_frame && !rx_valid) begin
                if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state    <= ST_ERROR;
                    boot_err <= 1'b1;
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end

            if (rx_valid) begin
                idle_cnt <= '0;
                case (state)
                    ST_IDLE, ST_ERROR: begin
                        if (rx_data == 8'hA5) begin
                            state    <= ST_LEN;
                            byte_cnt <= '0;
                            boot_err <= 1'b0;
                        end
                    end
                    ST_LEN: begin
                        shift_reg <= next_word;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            len_words <= next_word;
                            // Unsigned compare: huge LEN values must be rejected too.
                            if ((next_word == 32'd0) || (next_word > IMEM_DEPTH)) begin
                                state    <= ST_ERROR;
                                boot_err <= 1'b1;
                            end else begin
                                state    <= ST_DATA;
                                word_idx <= '0;
                                csum     <= '0;
                            end
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= next_word;
                        csum      <= csum ^ rx_data;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_wr_en <= 1'b1;
                            imem_wAddr <= BASE_ADDR + word_offset;
                            imem_wData <= next_word;
                            word_idx   <= word_idx + IDX_W'(1);
                            if (last_word) begin
                                state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == csum) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                            boot_done  <= 1'b1;
                        end else begin
                            state    <= ST_ERROR;
                            boot_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_boot_loader
// Self-checking bench for instr_boot_loader. Random images are sent as byte
// frames with random inter-byte gaps. The expected memory writes and boot
// status come from a simple model: word i lands at BASE + 4*i, and the
// checksum is the XOR of every payload byte.
// ---------------------------------------------------------------------------
module tb_instr_boot_loader;

    localparam int unsigned IMEM_DEPTH  = 8;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0040;
    localparam int unsigned TIMEOUT_CYC = 40;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_wr_en;
    logic [31:0] imem_wAddr;
    logic [31:0] imem_wData;
    logic        core_reset;
    logic        boot_done;
    logic        boot_err;

    int tests_run;
    int tests_failed;

    logic [31:0] img[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instr_boot_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .imem_wr_en(imem_wr_en),
        .imem_wAddr(imem_wAddr),
        .imem_wData(imem_wData),
        .core_reset(core_reset),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe away from the active edge.
    always @(negedge clk) begin
        if (imem_wr_en === 1'b1) begin
            wr_addr_q.push_back(imem_wAddr);
            wr_data_q.push_back(imem_wData);
        end
    end

    // Reference model: where word i of the image must land.
    function automatic logic [31:0] exp_addr(input int i);
        return BASE_ADDR + 32'(i) * 32'd4;
    endfunction

    // Reference model: XOR of all payload bytes.
    function automatic logic [7:0] model_csum();
        logic [7:0] c;
        c = 8'h00;
        foreach (img[i]) c ^= img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        return c;
    endfunction

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_writes();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one byte for one cycle after a random gap; returns on the
    // negedge following the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_header(input bit with_sync, input logic [31:0] len, input int max_gap);
        if (with_sync) send_byte(8'hA5, max_gap);
        for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], max_gap);
    endtask

    task automatic send_payload(input int max_gap);
        foreach (img[i]) begin
            for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], max_gap);
        end
    endtask

    task automatic send_frame(input bit with_sync, input logic [7:0] csum_byte, input int max_gap);
        send_header(with_sync, 32'(img.size()), max_gap);
        send_payload(max_gap);
        send_byte(csum_byte, max_gap);
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({imem_wr_en, imem_wAddr, imem_wData, core_reset, boot_done, boot_err} !==
            {1'b0, BASE_ADDR, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got wr=%b addr=%h data=%h cr=%b done=%b err=%b, expected 0 %h 0 1 0 0",
                     imem_wr_en, imem_wAddr, imem_wData, core_reset, boot_done, boot_err, BASE_ADDR);
        end
    endtask

    task automatic test_good_boot();
        do_reset();
        img.delete();
        img.push_back(32'h0050_0093);
        img.push_back(32'h00A0_0113);
        send_frame(1'b1, model_csum(), 2);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL good_boot_release: got cr/done/err=%b%b%b, expected 010",
                     core_reset, boot_done, boot_err);
        end
        tests_run++;
        if (wr_data_q.size() !== img.size()) begin
            tests_failed++;
            $display("[TB] FAIL good_boot_count: got %0d writes, expected %0d", wr_data_q.size(), img.size());
        end else begin
            foreach (img[i]) begin
                tests_run++;
                if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr(i), img[i]}) begin
                    tests_failed++;
                    $display("[TB] FAIL good_boot_write%0d: got %h:%h, expected %h:%h",
                             i, wr_addr_q[i], wr_data_q[i], exp_addr(i), img[i]);
                end
            end
        end
    endtask

    task automatic test_strobe_timing();
        do_reset();
        fill_img(1);
        send_header(1'b1, 32'd1, 0);
        for (int k = 0; k < 3; k++) send_byte(img[0][8*k +: 8], 0);
        tests_run++;
        if (imem_wr_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_early: got wr=%b, expected 0", imem_wr_en);
        end
        send_byte(img[0][31:24], 0);
        tests_run++;
        if ({imem_wr_en, imem_wAddr, imem_wData} !== {1'b1, exp_addr(0), img[0]}) begin
            tests_failed++;
            $display("[TB] FAIL strobe_cycle: got %b %h %h, expected 1 %h %h",
                     imem_wr_en, imem_wAddr, imem_wData, exp_addr(0), img[0]);
        end
        idle(1);
        tests_run++;
        if ({imem_wr_en, boot_done} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL strobe_width: got wr/done=%b%b, expected 00", imem_wr_en, boot_done);
        end
        send_byte(model_csum(), 0);
        tests_run++;
        if ({core_reset, boot_done} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL release_latency: got cr/done=%b%b, expected 01", core_reset, boot_done);
        end
    endtask

    task automatic test_random_boots();
        for (int r = 0; r < 4; r++) begin
            logic [7:0] junk;
            do_reset();
            fill_img($urandom_range(IMEM_DEPTH, 1));
            send_byte(8'h00, 2);
            send_byte(8'hFF, 2);
            for (int g = 0; g < 3; g++) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 3);
            end
            send_frame(1'b1, model_csum(), 3);
            tests_run++;
            if ({core_reset, boot_done, boot_err} !== 3'b010) begin
                tests_failed++;
                $display("[TB] FAIL random_boot%0d_status: got %b%b%b, expected 010",
                         r, core_reset, boot_done, boot_err);
            end
            tests_run++;
            if (wr_data_q.size() !== img.size()) begin
                tests_failed++;
                $display("[TB] FAIL random_boot%0d_count: got %0d, expected %0d", r, wr_data_q.size(), img.size());
            end else begin
                foreach (img[i]) begin
                    tests_run++;
                    if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr(i), img[i]}) begin
                        tests_failed++;
                        $display("[TB] FAIL random_boot%0d_write%0d: got %h:%h, expected %h:%h",
                                 r, i, wr_addr_q[i], wr_data_q[i], exp_addr(i), img[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        fill_img(2);
        send_frame(1'b1, model_csum() + 8'd1, 1);
        tests_run++;
        if ({core_reset, boot_done, boot_err, wr_data_q.size() == 2} !== 4'b1011) begin
            tests_failed++;
            $display("[TB] FAIL bad_csum_error: got cr/done/err=%b%b%b writes=%0d, expected 101 writes=2",
                     core_reset, boot_done, boot_err, wr_data_q.size());
        end
        clear_writes();
        fill_img(3);
        send_byte(8'hA5, 1);
        tests_run++;
        if (boot_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_csum_err_clear: got err=%b, expected 0", boot_err);
        end
        send_frame(1'b0, model_csum(), 1);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010 || wr_data_q.size() !== 3 || wr_data_q[2] !== img[2]) begin
            tests_failed++;
            $display("[TB] FAIL bad_csum_recover: got %b%b%b writes=%0d, expected 010 writes=3",
                     core_reset, boot_done, boot_err, wr_data_q.size());
        end
    endtask

    task automatic test_len_bounds();
        logic [31:0] bad_len[3];
        bad_len[0] = 32'd0;
        bad_len[1] = IMEM_DEPTH + 1;
        bad_len[2] = 32'h8000_0005;
        do_reset();
        foreach (bad_len[b]) begin
            send_header(1'b1, bad_len[b], 1);
            send_byte(8'h11, 1);
            tests_run++;
            if ({core_reset, boot_done, boot_err} !== 3'b101 || wr_data_q.size() !== 0) begin
                tests_failed++;
                $display("[TB] FAIL len_bound_%h: got %b%b%b writes=%0d, expected 101 writes=0",
                         bad_len[b], core_reset, boot_done, boot_err, wr_data_q.size());
            end
        end
        fill_img(IMEM_DEPTH);
        send_frame(1'b1, model_csum(), 1);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010 || wr_data_q.size() !== IMEM_DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL len_max_boot: got %b%b%b writes=%0d, expected 010 writes=%0d",
                     core_reset, boot_done, boot_err, wr_data_q.size(), IMEM_DEPTH);
        end else begin
            tests_run++;
            if ({wr_addr_q[IMEM_DEPTH-1], wr_data_q[IMEM_DEPTH-1]} !== {exp_addr(IMEM_DEPTH-1), img[IMEM_DEPTH-1]}) begin
                tests_failed++;
                $display("[TB] FAIL len_max_last_write: got %h:%h, expected %h:%h",
                         wr_addr_q[IMEM_DEPTH-1], wr_data_q[IMEM_DEPTH-1],
                         exp_addr(IMEM_DEPTH-1), img[IMEM_DEPTH-1]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        fill_img(2);
        send_header(1'b1, 32'd2, 0);
        send_byte(img[0][7:0], 0);
        send_byte(img[0][15:8], 0);
        idle(TIMEOUT_CYC - 1);
        tests_run++;
        if (boot_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: got err=%b, expected 0", boot_err);
        end
        idle(1);
        tests_run++;
        if ({core_reset, boot_err} !== 2'b11 || wr_data_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_abort: got cr/err=%b%b writes=%0d, expected 11 writes=0",
                     core_reset, boot_err, wr_data_q.size());
        end
        // A fresh frame must not inherit the discarded partial word.
        fill_img(1);
        send_header(1'b1, 32'd1, 0);
        send_byte(img[0][7:0], 0);
        send_byte(img[0][15:8], 0);
        idle(TIMEOUT_CYC - 1);
        send_byte(img[0][23:16], 0);
        tests_run++;
        if (boot_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_expiry_byte: got err=%b, expected 0", boot_err);
        end
        idle(TIMEOUT_CYC - 1);
        send_byte(img[0][31:24], 0);
        send_byte(model_csum(), 0);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010 || wr_data_q.size() !== 1 || wr_data_q[0] !== img[0]) begin
            tests_failed++;
            $display("[TB] FAIL timeout_recover: got %b%b%b writes=%0d, expected 010 writes=1",
                     core_reset, boot_done, boot_err, wr_data_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        fill_img(3);
        send_header(1'b1, 32'd3, 1);
        for (int k = 0; k < 9; k++) send_byte(img[k/4][8*(k%4) +: 8], 1);
        tests_run++;
        if (wr_data_q.size() !== 2) begin
            tests_failed++;
            $display("[TB] FAIL midreset_prewrites: got %0d, expected 2", wr_data_q.size());
        end
        reset = 1'b1;
        idle(1);
        tests_run++;
        if ({imem_wr_en, imem_wAddr, imem_wData, core_reset, boot_done, boot_err} !==
            {1'b0, BASE_ADDR, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL midreset_values: got %b %h %h %b%b%b, expected 0 %h 0 100",
                     imem_wr_en, imem_wAddr, imem_wData, core_reset, boot_done, boot_err, BASE_ADDR);
        end
        reset = 1'b0;
        clear_writes();
        fill_img(2);
        send_frame(1'b1, model_csum(), 1);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010 || wr_data_q.size() !== 2 ||
            wr_data_q[0] !== img[0] || wr_addr_q[1] !== exp_addr(1)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_reboot: got %b%b%b writes=%0d, expected 010 writes=2",
                     core_reset, boot_done, boot_err, wr_data_q.size());
        end
    endtask

    task automatic test_run_ignores();
        // Continues from the booted state left by the previous task.
        clear_writes();
        fill_img(1);
        send_byte(8'hA5, 1);
        send_frame(1'b1, model_csum(), 1);
        idle(2);
        tests_run++;
        if ({core_reset, boot_done, boot_err} !== 3'b010 || wr_data_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL run_ignores: got %b%b%b writes=%0d, expected 010 writes=0",
                     core_reset, boot_done, boot_err, wr_data_q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_boot();
        test_strobe_timing();
        test_random_boots();
        test_bad_csum();
        test_len_bounds();
        test_timeout();
        test_reset_mid_frame();
        test_run_ignores();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
